mips_bus_arbiter: RTL and testbench

- Two-master to one-slave arbiter for the CPU memory bus.
- Lets master 0 (instruction fetch) and master 1 (data load/store) share one memory port, such as the RAM_32x4096 bench model, using the same read/write/waitrequest handshake as mips_cpu_bus.
- Grants whole transfers, one at a time, with round-robin or fixed priority.
- Sits between the CPU-internal fetch and data ports and the external bus pins.

---
 rtl/mips_bus_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mips_bus_arbiter.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mips_bus_arbiter
//
// Two-master to one-slave arbiter for the CPU memory bus. Master 0 is the
// instruction-fetch port and master 1 the data load/store port. Both share a
// single memory port using the read/write/waitrequest handshake of
// mips_cpu_bus. Whole transfers are granted one at a time, round-robin or
// with master 0 at fixed priority.
//
// Parameters
//   FIXED_PRIORITY : 0 = round-robin, 1 = master 0 wins every contention
//
// Ports
//   clk, reset                  rising-edge clock, asynchronous active-low reset
//   mN_address/_read/_write     master N request (N = 0, 1)
//   mN_writedata/_byteenable    master N write data and byte lanes
//   mN_waitrequest/_readdata    stall and read data back to master N
//   s_address/_read/_write      request forwarded to the slave
//   s_writedata/_byteenable     write data and byte lanes to the slave
//   s_waitrequest/_readdata     slave stall and read data
// ---------------------------------------------------------------------------
module mips_bus_arbiter #(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_byteenable,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,

    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,

    output logic [31:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    input  logic        s_waitrequest,
    input  logic [31:0] s_readdata
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    localparam logic FIXED = (FIXED_PRIORITY != 0);

    state_t state_q, state_d;
    logic   last_q, last_d;     // master that completed the most recent transfer

    logic req0, req1;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // -----------------------------------------------------------------------
    // State register. Reset lands in IDLE with last=1 so that the first
    // contention after reset goes to master 0 in round-robin mode too.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic.
    // A granted master keeps the bus until its transfer completes (request
    // held while the slave does not stall) or it drops the request (abort,
    // last left untouched). On completion the bus passes straight to the
    // other master if it is waiting; the completing master is never
    // re-granted on the same edge, so it always sees one IDLE cycle.
    // In fixed-priority mode a completion by master 0 returns through IDLE
    // instead of handing over, so master 0 wins the re-arbitration whenever
    // it asks again and master 1 only gets in once master 0 is quiet.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = (FIXED || last_q) ? GNT0 : GNT1;
                end else if (req0) begin
                    state_d = GNT0;
                end else if (req1) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!req0) begin
                    state_d = IDLE;
                end else if (!s_waitrequest) begin
                    last_d  = 1'b0;
                    state_d = (req1 && !FIXED) ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!req1) begin
                    state_d = IDLE;
                end else if (!s_waitrequest) begin
                    last_d  = 1'b1;
                    state_d = req0 ? GNT0 : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Bus steering. Outputs depend only on the registered state plus the
    // granted master's signals, so in IDLE the waitrequests are constant 1
    // and there is no combinational path from the master inputs. Because the
    // state register clears asynchronously, the slave strobes drop the
    // moment reset is asserted. Read and write asserted together are passed
    // through untouched.
    // -----------------------------------------------------------------------
    always_comb begin
        s_address      = 32'h0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = 32'h0;
        s_byteenable   = 4'h0;
        m0_waitrequest = 1'b1;
        m0_readdata    = 32'h0;
        m1_waitrequest = 1'b1;
        m1_readdata    = 32'h0;
        case (state_q)
            GNT0: begin
                s_address      = m0_address;
                s_read         = m0_read;
                s_write        = m0_write;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                m0_waitrequest = s_waitrequest;
                m0_readdata    = s_readdata;
            end
            GNT1: begin
                s_address      = m1_address;
                s_read         = m1_read;
                s_write        = m1_write;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                m1_waitrequest = s_waitrequest;
                m1_readdata    = s_readdata;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for mips_bus_arbiter. Two instances share all master inputs and
// the slave stall: index 0 is round-robin, index 1 is fixed priority. A
// 16-word RAM answers reads for both and accepts writes from instance 0.
// ---------------------------------------------------------------------------
module tb_mips_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // master-side stimulus, shared by both instances
    logic        m_rd    [2];
    logic        m_wr    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_be    [2];
    logic        s_waitrequest;

    // per-instance outputs, [dut] or [dut][master]
    logic        wait_o    [2][2];
    logic [31:0] rdata_o   [2][2];
    logic [31:0] s_addr_o  [2];
    logic        s_rd_o    [2];
    logic        s_wr_o    [2];
    logic [31:0] s_wdata_o [2];
    logic [3:0]  s_be_o    [2];
    logic [31:0] s_rdata_i [2];

    logic [31:0] mem [16];

    int tests;
    int fails;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            mips_bus_arbiter #(.FIXED_PRIORITY(gi)) dut (
                .clk            (clk),
                .reset          (reset),
                .m0_address     (m_addr[0]),
                .m0_read        (m_rd[0]),
                .m0_write       (m_wr[0]),
                .m0_writedata   (m_wdata[0]),
                .m0_byteenable  (m_be[0]),
                .m0_waitrequest (wait_o[gi][0]),
                .m0_readdata    (rdata_o[gi][0]),
                .m1_address     (m_addr[1]),
                .m1_read        (m_rd[1]),
                .m1_write       (m_wr[1]),
                .m1_writedata   (m_wdata[1]),
                .m1_byteenable  (m_be[1]),
                .m1_waitrequest (wait_o[gi][1]),
                .m1_readdata    (rdata_o[gi][1]),
                .s_address      (s_addr_o[gi]),
                .s_read         (s_rd_o[gi]),
                .s_write        (s_wr_o[gi]),
                .s_writedata    (s_wdata_o[gi]),
                .s_byteenable   (s_be_o[gi]),
                .s_waitrequest  (s_waitrequest),
                .s_readdata     (s_rdata_i[gi])
            );
            assign s_rdata_i[gi] = mem[s_addr_o[gi][5:2]];
        end
    endgenerate

    // RAM: reloaded while reset is held, written by the round-robin instance
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[1] <= 32'hBABA0000;
        end else if (s_wr_o[0] && !s_waitrequest) begin
            for (int b = 0; b < 4; b++)
                if (s_be_o[0][b]) mem[s_addr_o[0][5:2]][8*b +: 8] <= s_wdata_o[0][8*b +: 8];
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_masters();
        for (int k = 0; k < 2; k++) begin
            m_rd[k] = 1'b0; m_wr[k] = 1'b0; m_addr[k] = 32'h0;
            m_wdata[k] = 32'h0; m_be[k] = 4'h0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_masters();
        s_waitrequest = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Reference arbiter: owner -1 = nobody, else master index.
    function automatic int arb_next(input int own, input int lst, input bit fixed,
                                    input bit r0, input bit r1, input bit sw,
                                    output int lst_n);
        bit r [2];
        r[0] = r0; r[1] = r1;
        lst_n = lst;
        if (own < 0) begin
            if (r0 && r1) return fixed ? 0 : 1 - lst;
            if (r0) return 0;
            if (r1) return 1;
            return -1;
        end
        if (!r[own]) return -1;
        if (sw) return own;
        lst_n = own;
        if (r[1-own] && !(fixed && own == 0)) return 1 - own;
        return -1;
    endfunction

    task automatic test_reset();
        m_rd[0] = 1'b1; m_wr[1] = 1'b1; m_addr[0] = 32'h44; m_wdata[1] = 32'h55;
        s_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            tests++;
            if ({s_rd_o[d], s_wr_o[d], s_addr_o[d], s_wdata_o[d], s_be_o[d], wait_o[d][0], wait_o[d][1],
                 rdata_o[d][0], rdata_o[d][1]} !== {2'b00, 32'h0, 32'h0, 4'h0, 2'b11, 32'h0, 32'h0}) begin
                fails++;
                $display("FAIL reset_state dut%0d: got rd=%b wr=%b addr=%h w0=%b w1=%b want all zero, waits 1",
                         d, s_rd_o[d], s_wr_o[d], s_addr_o[d], wait_o[d][0], wait_o[d][1]);
            end
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_single_read();
        do_reset();
        m_rd[0] = 1'b1; m_addr[0] = 32'h4; m_be[0] = 4'hF;
        @(negedge clk);
        tests++;
        if ({s_rd_o[0], wait_o[0][0]} !== 2'b01) begin
            fails++; $display("FAIL sr_idle_cycle: got %b want 01", {s_rd_o[0], wait_o[0][0]});
        end
        cyc(); @(negedge clk);
        tests++;
        if ({s_rd_o[0], s_addr_o[0], wait_o[0][0], wait_o[0][1]} !== {1'b1, 32'h4, 2'b11}) begin
            fails++; $display("FAIL sr_grant: got rd=%b addr=%h w0=%b w1=%b want 1 4 1 1",
                              s_rd_o[0], s_addr_o[0], wait_o[0][0], wait_o[0][1]);
        end
        cyc(); s_waitrequest = 1'b0; @(negedge clk);
        tests++;
        if ({wait_o[0][0], rdata_o[0][0], wait_o[0][1], rdata_o[0][1]} !== {1'b0, 32'hBABA0000, 1'b1, 32'h0}) begin
            fails++; $display("FAIL sr_data: got w0=%b rd0=%h w1=%b rd1=%h want 0 BABA0000 1 0",
                              wait_o[0][0], rdata_o[0][0], wait_o[0][1], rdata_o[0][1]);
        end
        cyc(); m_rd[0] = 1'b0; @(negedge clk);
        tests++;
        if ({s_rd_o[0], wait_o[0][0]} !== 2'b01) begin
            fails++; $display("FAIL sr_release: got %b want 01", {s_rd_o[0], wait_o[0][0]});
        end
        $display("[TB] test_single_read done");
    endtask

    task automatic test_contention();
        do_reset();
        m_rd[0] = 1'b1; m_addr[0] = 32'h0; m_be[0] = 4'hF;
        m_wr[1] = 1'b1; m_addr[1] = 32'h10; m_wdata[1] = 32'hBABAFFFF; m_be[1] = 4'hF;
        s_waitrequest = 1'b0;
        @(negedge clk);
        tests++;
        if ({s_rd_o[0], s_wr_o[0], wait_o[0][0], wait_o[0][1]} !== 4'b0011) begin
            fails++; $display("FAIL ct_idle: got %b want 0011", {s_rd_o[0], s_wr_o[0], wait_o[0][0], wait_o[0][1]});
        end
        cyc(); @(negedge clk);
        tests++;
        if ({s_rd_o[0], s_wr_o[0], s_addr_o[0], wait_o[0][0], wait_o[0][1]} !== {2'b10, 32'h0, 2'b01}) begin
            fails++; $display("FAIL ct_first_m0: got rd=%b wr=%b addr=%h w0=%b w1=%b want 1 0 0 0 1",
                              s_rd_o[0], s_wr_o[0], s_addr_o[0], wait_o[0][0], wait_o[0][1]);
        end
        cyc(); m_rd[0] = 1'b0; @(negedge clk);
        tests++;
        if ({s_rd_o[0], s_wr_o[0], s_addr_o[0], s_wdata_o[0], s_be_o[0], wait_o[0][1], wait_o[0][0]}
            !== {2'b01, 32'h10, 32'hBABAFFFF, 4'hF, 2'b01}) begin
            fails++; $display("FAIL ct_then_m1: got wr=%b addr=%h wd=%h be=%h w1=%b w0=%b want 1 10 BABAFFFF F 0 1",
                              s_wr_o[0], s_addr_o[0], s_wdata_o[0], s_be_o[0], wait_o[0][1], wait_o[0][0]);
        end
        cyc(); m_wr[1] = 1'b0; m_rd[0] = 1'b1; m_addr[0] = 32'h10;
        @(negedge clk);
        tests++;
        if ({s_rd_o[0], wait_o[0][0]} !== 2'b01) begin
            fails++; $display("FAIL ct_gap: got %b want 01", {s_rd_o[0], wait_o[0][0]});
        end
        cyc(); @(negedge clk);
        tests++;
        if ({s_rd_o[0], wait_o[0][0], rdata_o[0][0]} !== {2'b10, 32'hBABAFFFF}) begin
            fails++; $display("FAIL ct_readback: got rd=%b w0=%b data=%h want 1 0 BABAFFFF",
                              s_rd_o[0], wait_o[0][0], rdata_o[0][0]);
        end
        cyc(); m_rd[0] = 1'b0;
        $display("[TB] test_contention done");
    endtask

    task automatic test_back_to_back();
        int exp_g [2][7];
        int got_g [2][7];
        bit found;
        exp_g[0] = '{-1, 0, 1, 0, 1, 0, 1};
        exp_g[1] = '{-1, 0, -1, 0, -1, 0, -1};
        do_reset();
        m_rd[0] = 1'b1; m_addr[0] = 32'h0;
        m_rd[1] = 1'b1; m_addr[1] = 32'h4;
        s_waitrequest = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                got_g[d][c] = !wait_o[d][0] ? 0 : (!wait_o[d][1] ? 1 : -1);
            cyc();
        end
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 7; c++) begin
                tests++;
                if (got_g[d][c] !== exp_g[d][c]) begin
                    fails++; $display("FAIL b2b_order dut%0d cycle %0d: got grant %0d want %0d",
                                      d, c, got_g[d][c], exp_g[d][c]);
                end
            end
        end
        // with master 0 quiet, the fixed-priority instance must serve master 1
        m_rd[0] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            @(negedge clk);
            if (!wait_o[1][1]) found = 1'b1;
            else cyc();
        end
        tests++;
        if (!found) begin
            fails++; $display("FAIL b2b_fp_m1: got no master-1 grant in 4 cycles want grant");
        end
        cyc(); m_rd[1] = 1'b0;
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_stall();
        logic [31:0] d;
        d = $urandom;
        do_reset();
        m_wr[1] = 1'b1; m_addr[1] = 32'h8; m_wdata[1] = d; m_be[1] = 4'hF;
        s_waitrequest = 1'b1;
        @(negedge clk);
        cyc();
        m_rd[0] = 1'b1; m_addr[0] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if ({s_wr_o[0], s_wdata_o[0], s_rd_o[0], wait_o[0][0], wait_o[0][1], s_wr_o[1], wait_o[1][0]}
                !== {1'b1, d, 1'b0, 2'b11, 2'b11}) begin
                fails++; $display("FAIL stall_hold cycle %0d: got wr=%b wd=%h rd=%b w0=%b w1=%b fpwr=%b fpw0=%b want 1 %h 0 1 1 1 1",
                                  i, s_wr_o[0], s_wdata_o[0], s_rd_o[0], wait_o[0][0], wait_o[0][1],
                                  s_wr_o[1], wait_o[1][0], d);
            end
            cyc();
        end
        s_waitrequest = 1'b0;
        @(negedge clk);
        tests++;
        if ({wait_o[0][1], wait_o[0][0], s_wr_o[0]} !== 3'b011) begin
            fails++; $display("FAIL stall_complete: got %b want 011", {wait_o[0][1], wait_o[0][0], s_wr_o[0]});
        end
        cyc(); m_wr[1] = 1'b0;
        @(negedge clk);
        tests++;
        if ({s_rd_o[0], s_wr_o[0], wait_o[0][0]} !== 3'b100) begin
            fails++; $display("FAIL stall_handover: got %b want 100", {s_rd_o[0], s_wr_o[0], wait_o[0][0]});
        end
        cyc(); m_rd[0] = 1'b0;
        $display("[TB] test_stall done");
    endtask

    task automatic test_async_reset();
        do_reset();
        m_wr[1] = 1'b1; m_addr[1] = 32'hC; m_wdata[1] = 32'h1234; m_be[1] = 4'hF;
        s_waitrequest = 1'b1;
        @(negedge clk);
        cyc(); @(negedge clk);
        tests++;
        if ({s_wr_o[0], wait_o[0][1]} !== 2'b11) begin
            fails++; $display("FAIL ar_pre: got %b want 11", {s_wr_o[0], wait_o[0][1]});
        end
        #2;
        reset = 1'b0;
        m_rd[0] = 1'b1; m_addr[0] = 32'h20;
        #1;
        tests++;
        if ({s_wr_o[0], s_rd_o[0], wait_o[0][1], wait_o[0][0], s_addr_o[0]} !== {4'b0011, 32'h0}) begin
            fails++; $display("FAIL ar_immediate: got wr=%b rd=%b w1=%b w0=%b addr=%h want 0 0 1 1 0",
                              s_wr_o[0], s_rd_o[0], wait_o[0][1], wait_o[0][0], s_addr_o[0]);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        s_waitrequest = 1'b0;
        @(negedge clk);
        tests++;
        if ({s_rd_o[0], s_wr_o[0], wait_o[0][0], wait_o[0][1]} !== 4'b0011) begin
            fails++; $display("FAIL ar_idle: got %b want 0011", {s_rd_o[0], s_wr_o[0], wait_o[0][0], wait_o[0][1]});
        end
        cyc(); @(negedge clk);
        tests++;
        if ({s_rd_o[0], s_addr_o[0], wait_o[0][0], wait_o[0][1]} !== {1'b1, 32'h20, 2'b01}) begin
            fails++; $display("FAIL ar_m0_first: got rd=%b addr=%h w0=%b w1=%b want 1 20 0 1",
                              s_rd_o[0], s_addr_o[0], wait_o[0][0], wait_o[0][1]);
        end
        cyc(); idle_masters();
        $display("[TB] test_async_reset done");
    endtask

    task automatic test_abort();
        do_reset();
        m_rd[0] = 1'b1; m_addr[0] = 32'h4;
        s_waitrequest = 1'b1;
        @(negedge clk);
        cyc(); @(negedge clk);
        tests++;
        if ({s_rd_o[0], wait_o[0][0]} !== 2'b11) begin
            fails++; $display("FAIL ab_grant: got %b want 11", {s_rd_o[0], wait_o[0][0]});
        end
        cyc(); m_rd[0] = 1'b0;
        @(negedge clk);
        tests++;
        if ({s_rd_o[0], s_wr_o[0]} !== 2'b00) begin
            fails++; $display("FAIL ab_no_strobe: got %b want 00", {s_rd_o[0], s_wr_o[0]});
        end
        cyc();
        m_rd[0] = 1'b1; m_rd[1] = 1'b1; m_addr[1] = 32'h8;
        s_waitrequest = 1'b0;
        @(negedge clk);
        tests++;
        if ({s_rd_o[0], s_wr_o[0], wait_o[0][0], wait_o[0][1]} !== 4'b0011) begin
            fails++; $display("FAIL ab_idle: got %b want 0011", {s_rd_o[0], s_wr_o[0], wait_o[0][0], wait_o[0][1]});
        end
        cyc(); @(negedge clk);
        tests++;
        if ({wait_o[0][0], wait_o[0][1]} !== 2'b01) begin
            fails++; $display("FAIL ab_last_kept: got w0w1=%b want 01", {wait_o[0][0], wait_o[0][1]});
        end
        cyc(); idle_masters();
        $display("[TB] test_abort done");
    endtask

    task automatic test_random();
        int own [2];
        int lst [2];
        int lst_n;
        int k;
        int sel;
        bit done [2];
        logic [135:0] got, exp;
        logic [31:0] ea;
        do_reset();
        for (int d = 0; d < 2; d++) begin own[d] = -1; lst[d] = 1; end
        done[0] = 1'b0; done[1] = 1'b0;
        for (int c = 0; c < 300; c++) begin
            for (int m = 0; m < 2; m++) begin
                if ((m_rd[m] || m_wr[m]) && !done[m]) begin
                    if ($urandom_range(0, 39) == 0) begin m_rd[m] = 1'b0; m_wr[m] = 1'b0; end
                end else if ($urandom_range(0, 2) != 0) begin
                    sel = $urandom_range(0, 7);
                    m_rd[m] = (sel < 4) || (sel == 7);
                    m_wr[m] = (sel >= 4);
                    m_addr[m] = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
                    m_wdata[m] = $urandom;
                    m_be[m] = 4'($urandom);
                end else begin
                    m_rd[m] = 1'b0; m_wr[m] = 1'b0;
                end
            end
            s_waitrequest = 1'($urandom_range(0, 1));
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                k = own[d];
                ea = (k >= 0) ? m_addr[k] : 32'h0;
                exp = {(k >= 0) ? m_rd[k] : 1'b0, (k >= 0) ? m_wr[k] : 1'b0, ea,
                       (k >= 0) ? m_wdata[k] : 32'h0, (k >= 0) ? m_be[k] : 4'h0,
                       (k == 0) ? s_waitrequest : 1'b1, (k == 1) ? s_waitrequest : 1'b1,
                       (k == 0) ? mem[ea[5:2]] : 32'h0, (k == 1) ? mem[ea[5:2]] : 32'h0};
                got = {s_rd_o[d], s_wr_o[d], s_addr_o[d], s_wdata_o[d], s_be_o[d],
                       wait_o[d][0], wait_o[d][1], rdata_o[d][0], rdata_o[d][1]};
                tests++;
                if (got !== exp) begin
                    fails++; $display("FAIL rand dut%0d cycle %0d owner %0d: got %h want %h", d, c, k, got, exp);
                end
            end
            for (int m = 0; m < 2; m++) begin
                done[m] = (own[0] == m) && (m_rd[m] || m_wr[m]) && !s_waitrequest;
                if (done[m])
                    $display("[TB] xfer cycle=%0d m%0d rd=%0b wr=%0b addr=%h", c, m, m_rd[m], m_wr[m], m_addr[m]);
            end
            for (int d = 0; d < 2; d++) begin
                own[d] = arb_next(own[d], lst[d], d == 1, m_rd[0] || m_wr[0], m_rd[1] || m_wr[1],
                                  s_waitrequest, lst_n);
                lst[d] = lst_n;
            end
            cyc();
        end
        idle_masters();
        $display("[TB] test_random done");
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        s_waitrequest = 1'b1;
        idle_masters();
        test_reset();
        test_single_read();
        test_contention();
        test_back_to_back();
        test_stall();
        test_async_reset();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule
